stream_reduce: RTL and testbench

Streaming, multi-beat reduction engine, the parametrised successor to the single-word combinational reduction block. It accepts a frame of `DATA_W`-bit beats over a valid/ready handshake and folds all bits of all beats with one selected operator (AND/OR/XOR and their inversions). It emits one registered result per frame together with a beat count. It sits between a packet source and the status/checksum logic that consumes per-frame parity and all-ones/all-zeros flags.

---
 rtl/stream_reduce_pkg.sv | 51 +++++
 rtl/stream_reduce_lane.sv | 39 +++
 rtl/stream_reduce.sv | 166 ++++++++++++++++
 tb/tb_stream_reduce.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stream_reduce_pkg.sv
// ============================================================================
// Module   : stream_reduce_pkg
// Purpose  : Shared types and operator helpers for the stream_reduce engine.
// Options  : STREAM_REDUCE_POPCOUNT_EN (used by the importing modules)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_reduce_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } reduce_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } reduce_state_e;

  localparam logic [1:0] c_FAM_AND = 2'd0;
  localparam logic [1:0] c_FAM_OR  = 2'd1;
  localparam logic [1:0] c_FAM_XOR = 2'd2;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

  function automatic logic is_inverting(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  // Illegal codes fall into the XOR family; their result is masked anyway.
  function automatic logic [1:0] op_family(input logic [2:0] op);
    logic [1:0] fam;
    case (op)
      OP_AND, OP_NAND: fam = c_FAM_AND;
      OP_OR,  OP_NOR:  fam = c_FAM_OR;
      default:         fam = c_FAM_XOR;
    endcase
    return fam;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_reduce_lane.sv
// ============================================================================
// Module   : reduce_lane
// Purpose  : Combinational per-beat AND/OR/XOR reducer, optional beat popcount.
// Options  : STREAM_REDUCE_POPCOUNT_EN adds o_ones
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_lane #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_and,
  output logic              o_or,
  output logic              o_xor
`ifdef STREAM_REDUCE_POPCOUNT_EN
  ,
  output logic [$clog2(DATA_W+1)-1:0] o_ones
`endif
);

  assign o_and = &i_data;
  assign o_or  = |i_data;
  assign o_xor = ^i_data;

`ifdef STREAM_REDUCE_POPCOUNT_EN
  localparam int PC_W = $clog2(DATA_W + 1);

  always_comb begin
    o_ones = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_ones = o_ones + PC_W'(i_data[i]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/stream_reduce.sv
// ============================================================================
// Module   : stream_reduce
// Purpose  : Multi-beat frame reducer (AND/OR/XOR and inversions), one
//            registered result plus saturating beat count per frame.
// Options  : STREAM_REDUCE_POPCOUNT_EN adds out_ones (frame popcount)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_reduce
  import stream_reduce_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        op_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_result,
  output logic [CNT_W-1:0]  out_beats,
  output logic              out_err
`ifdef STREAM_REDUCE_POPCOUNT_EN
  ,
  output logic [CNT_W+$clog2(DATA_W+1)-1:0] out_ones
`endif
);

  reduce_state_e    r_state, w_state_nxt;
  logic             r_in_ready;
  logic [2:0]       r_op;
  logic             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid, r_out_result, r_out_err;
  logic [CNT_W-1:0] r_out_beats;

  logic             w_accept, w_first, w_done, w_take;
  logic [2:0]       w_op;
  logic [1:0]       w_fam;
  logic             w_acc_prev, w_acc_new;
  logic [CNT_W-1:0] w_cnt_new;
  logic             w_beat_and, w_beat_or, w_beat_xor;

  assign w_accept = in_valid & r_in_ready;
  assign w_first  = (r_state == ST_IDLE);
  assign w_done   = w_accept & in_last;
  assign w_take   = r_out_valid & out_ready;
  // The operator is frozen at the first beat; later op_sel changes are ignored.
  assign w_op     = w_first ? op_sel : r_op;

`ifdef STREAM_REDUCE_POPCOUNT_EN
  localparam int PC_W   = $clog2(DATA_W + 1);
  localparam int ONES_W = CNT_W + PC_W;

  logic [PC_W-1:0]   w_beat_ones;
  logic [ONES_W:0]   w_ones_sum;
  logic [ONES_W-1:0] w_ones_new;
  logic [ONES_W-1:0] r_ones, r_out_ones;

  reduce_lane #(.DATA_W(DATA_W)) u_lane (
    .i_data (in_data),
    .o_and  (w_beat_and),
    .o_or   (w_beat_or),
    .o_xor  (w_beat_xor),
    .o_ones (w_beat_ones)
  );

  assign w_ones_sum = (w_first ? '0 : {1'b0, r_ones}) + (ONES_W+1)'(w_beat_ones);
  assign w_ones_new = w_ones_sum[ONES_W] ? '1 : w_ones_sum[ONES_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones     <= '0;
      r_out_ones <= '0;
    end else begin
      if (w_accept) r_ones <= w_ones_new;
      if (w_done)   r_out_ones <= w_ones_new;
    end
  end

  assign out_ones = r_out_ones;
`else
  reduce_lane #(.DATA_W(DATA_W)) u_lane (
    .i_data (in_data),
    .o_and  (w_beat_and),
    .o_or   (w_beat_or),
    .o_xor  (w_beat_xor)
  );
`endif

  // First beat folds into the family identity, so IDLE and ACCUM share one path.
  always_comb begin
    w_fam      = op_family(w_op);
    w_acc_prev = w_first ? (w_fam == c_FAM_AND) : r_acc;
    case (w_fam)
      c_FAM_AND: w_acc_new = w_acc_prev & w_beat_and;
      c_FAM_OR:  w_acc_new = w_acc_prev | w_beat_or;
      default:   w_acc_new = w_acc_prev ^ w_beat_xor;
    endcase
  end

  assign w_cnt_new = w_first ? CNT_W'(1) :
                     ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (w_done)   w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_take)   w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_HOLD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_acc <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_acc <= w_acc_new;
      r_cnt <= w_cnt_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 1'b0;
      r_out_beats  <= '0;
      r_out_err    <= 1'b0;
    end else if (w_done) begin
      r_out_valid  <= 1'b1;
      r_out_result <= op_is_legal(w_op) & (w_acc_new ^ is_inverting(w_op));
      r_out_beats  <= w_cnt_new;
      r_out_err    <= ~op_is_legal(w_op);
    end else if (w_take) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_beats  = r_out_beats;
  assign out_err    = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_stream_reduce.sv
// ============================================================================
// Module   : tb_stream_reduce
// Purpose  : Directed self-checking bench; second instance uses CNT_W=2.
// Options  : STREAM_REDUCE_POPCOUNT_EN enables out_ones checks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_reduce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [2:0] op_sel = 3'd0;

  logic        a_in_ready, a_out_valid, a_out_result, a_out_err;
  logic [15:0] a_out_beats;
  logic        b_in_ready, b_out_valid, b_out_result, b_out_err;
  logic [1:0]  b_out_beats;
`ifdef STREAM_REDUCE_POPCOUNT_EN
  logic [19:0] a_out_ones;
  logic [5:0]  b_out_ones;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_reduce #(.DATA_W(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .op_sel(op_sel),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
    .out_beats(a_out_beats), .out_err(a_out_err)
`ifdef STREAM_REDUCE_POPCOUNT_EN
    , .out_ones(a_out_ones)
`endif
  );

  stream_reduce #(.DATA_W(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .op_sel(op_sel),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
    .out_beats(b_out_beats), .out_err(b_out_err)
`ifdef STREAM_REDUCE_POPCOUNT_EN
    , .out_ones(b_out_ones)
`endif
  );

  task automatic send_beat(input logic [7:0] d, input logic l, input logic [2:0] op);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; op_sel = op;
    while (!a_in_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL beat_accept_timeout in_ready=%0b required=1", a_in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_result !== 1'b0) begin failures++; $display("FAIL rst_result got=%0b exp=0", a_out_result); end
    checks++; if (a_out_beats !== 16'd0) begin failures++; $display("FAIL rst_beats got=%0d exp=0", a_out_beats); end
    checks++; if (a_out_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", a_out_err); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", a_in_ready); end
  endtask

  task automatic test_and_1beat();
    send_beat(8'hFF, 1'b1, 3'd0);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL and_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_result !== 1'b1) begin failures++; $display("FAIL and_result got=%0b exp=1", a_out_result); end
    checks++; if (a_out_beats !== 16'd1) begin failures++; $display("FAIL and_beats got=%0d exp=1", a_out_beats); end
    checks++; if (a_out_err !== 1'b0) begin failures++; $display("FAIL and_err got=%0b exp=0", a_out_err); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL and_hold_ready got=%0b exp=0", a_in_ready); end
    take_output();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL and_taken_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL and_ready_back got=%0b exp=1", a_in_ready); end
  endtask

  task automatic test_xnor_gaps();
    send_beat(8'h01, 1'b0, 3'd5);
    repeat (2) @(posedge clk);
    #1;
    send_beat(8'h03, 1'b0, 3'd1);
    @(posedge clk); #1;
    send_beat(8'h00, 1'b1, 3'd1);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL xnor_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_result !== 1'b0) begin failures++; $display("FAIL xnor_result got=%0b exp=0", a_out_result); end
    checks++; if (a_out_beats !== 16'd3) begin failures++; $display("FAIL xnor_beats got=%0d exp=3", a_out_beats); end
    checks++; if (a_out_err !== 1'b0) begin failures++; $display("FAIL xnor_err got=%0b exp=0", a_out_err); end
`ifdef STREAM_REDUCE_POPCOUNT_EN
    checks++; if (a_out_ones !== 20'd3) begin failures++; $display("FAIL xnor_ones got=%0d exp=3", a_out_ones); end
`endif
    take_output();
  endtask

  task automatic test_nor_hold();
    send_beat(8'h00, 1'b0, 3'd4);
    send_beat(8'h10, 1'b1, 3'd4);
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL nor_hold_valid cyc=%0d got=%0b exp=1", i, a_out_valid); end
      checks++; if (a_out_result !== 1'b0) begin failures++; $display("FAIL nor_hold_result cyc=%0d got=%0b exp=0", i, a_out_result); end
      checks++; if (a_out_beats !== 16'd2) begin failures++; $display("FAIL nor_hold_beats cyc=%0d got=%0d exp=2", i, a_out_beats); end
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL nor_hold_ready cyc=%0d got=%0b exp=0", i, a_in_ready); end
      @(posedge clk); #1;
    end
    take_output();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL nor_taken_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL nor_ready_back got=%0b exp=1", a_in_ready); end
  endtask

  task automatic test_illegal();
    send_beat(8'hFF, 1'b0, 3'd7);
    send_beat(8'h0F, 1'b1, 3'd7);
    checks++; if (a_out_err !== 1'b1) begin failures++; $display("FAIL ill_err got=%0b exp=1", a_out_err); end
    checks++; if (a_out_result !== 1'b0) begin failures++; $display("FAIL ill_result got=%0b exp=0", a_out_result); end
    checks++; if (a_out_beats !== 16'd2) begin failures++; $display("FAIL ill_beats got=%0d exp=2", a_out_beats); end
    take_output();
    send_beat(8'h80, 1'b1, 3'd1);
    checks++; if (a_out_err !== 1'b0) begin failures++; $display("FAIL ill_next_err got=%0b exp=0", a_out_err); end
    checks++; if (a_out_result !== 1'b1) begin failures++; $display("FAIL ill_next_result got=%0b exp=1", a_out_result); end
    checks++; if (a_out_beats !== 16'd1) begin failures++; $display("FAIL ill_next_beats got=%0d exp=1", a_out_beats); end
    take_output();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) send_beat(8'hFF, (i == 4), 3'd0);
    checks++; if (a_out_beats !== 16'd5) begin failures++; $display("FAIL sat_beats_wide got=%0d exp=5", a_out_beats); end
    checks++; if (b_out_beats !== 2'd3) begin failures++; $display("FAIL sat_beats_narrow got=%0d exp=3", b_out_beats); end
    checks++; if (b_out_result !== 1'b1) begin failures++; $display("FAIL sat_result got=%0b exp=1", b_out_result); end
`ifdef STREAM_REDUCE_POPCOUNT_EN
    checks++; if (a_out_ones !== 20'd40) begin failures++; $display("FAIL sat_ones_wide got=%0d exp=40", a_out_ones); end
    checks++; if (b_out_ones !== 6'd40) begin failures++; $display("FAIL sat_ones_narrow got=%0d exp=40", b_out_ones); end
`endif
    take_output();
  endtask

  task automatic test_back_to_back();
    send_beat(8'h07, 1'b1, 3'd2);
    checks++; if (a_out_result !== 1'b1) begin failures++; $display("FAIL b2b_xor_result got=%0b exp=1", a_out_result); end
    take_output();
    send_beat(8'hFE, 1'b1, 3'd3);
    checks++; if (a_out_result !== 1'b1) begin failures++; $display("FAIL b2b_nand_result got=%0b exp=1", a_out_result); end
    checks++; if (a_out_beats !== 16'd1) begin failures++; $display("FAIL b2b_nand_beats got=%0d exp=1", a_out_beats); end
    take_output();
  endtask

  task automatic test_reset_midframe();
    send_beat(8'hFF, 1'b0, 3'd1);
    send_beat(8'hFF, 1'b0, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_out_result !== 1'b0) begin failures++; $display("FAIL mrst_result got=%0b exp=0", a_out_result); end
    checks++; if (a_out_beats !== 16'd0) begin failures++; $display("FAIL mrst_beats got=%0d exp=0", a_out_beats); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%0b exp=0", a_out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_beat(8'h00, 1'b1, 3'd1);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL mrst_new_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_result !== 1'b0) begin failures++; $display("FAIL mrst_new_result got=%0b exp=0", a_out_result); end
    checks++; if (a_out_beats !== 16'd1) begin failures++; $display("FAIL mrst_new_beats got=%0d exp=1", a_out_beats); end
    checks++; if (a_out_err !== 1'b0) begin failures++; $display("FAIL mrst_new_err got=%0b exp=0", a_out_err); end
`ifdef STREAM_REDUCE_POPCOUNT_EN
    checks++; if (a_out_ones !== 20'd0) begin failures++; $display("FAIL mrst_new_ones got=%0d exp=0", a_out_ones); end
`endif
    take_output();
  endtask

  initial begin
    test_reset();
    test_and_1beat();
    test_xnor_gaps();
    test_nor_hold();
    test_illegal();
    test_saturate();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
